// File: rtl/rdc_duration_monitor.sv
// rdc_duration_monitor: per-channel request duration counters with sticky overrun flags and summary irq.
// Optional per-channel max-count watermarks are built when RDC_WATERMARK_EN is defined.
module rdc_duration_monitor #(
   parameter int N_CORES       = 4,
   parameter int CORE_EVENTS   = 4,
   parameter int WEIGHTS_WIDTH = 8,
   parameter int CNT_WIDTH     = 16,
   localparam int N_CH         = N_CORES * CORE_EVENTS
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          enable_i,
   input  logic                          clear_i,
   input  logic                          mode_i,
   input  logic [N_CH-1:0]               events_i,
   input  logic [N_CH*WEIGHTS_WIDTH-1:0] events_weights_i,
   output logic [N_CH-1:0]               interruption_vector_rdc_o,
   output logic                          interruption_rdc_o,
   output logic [N_CH*CNT_WIDTH-1:0]     watermark_o
);
   if (CNT_WIDTH < WEIGHTS_WIDTH) begin : g_bad_width
      $error("CNT_WIDTH must be >= WEIGHTS_WIDTH");
   end
   logic [N_CH-1:0] over;
   logic [N_CH-1:0] vec_nxt;
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [WEIGHTS_WIDTH-1:0] w;
      logic [CNT_WIDTH-1:0]     cnt;
      logic [CNT_WIDTH-1:0]     cnt_nxt;
      assign w       = events_weights_i[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH];
      assign over[k] = (w != '0) && (cnt > CNT_WIDTH'(w));
      // saturate rather than wrap so a stuck request keeps flagging
      assign cnt_nxt = (clear_i || !enable_i || w == '0) ? '0 :
                       events_i[k] ? ((&cnt) ? cnt : cnt + CNT_WIDTH'(1)) :
                       mode_i ? cnt : '0;
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) cnt <= '0;
         else         cnt <= cnt_nxt;
      end
`ifdef RDC_WATERMARK_EN
      logic [CNT_WIDTH-1:0] wm;
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i)                   wm <= '0;
         else if (clear_i)              wm <= '0;
         else if (enable_i && cnt > wm) wm <= cnt;
      end
      assign watermark_o[k*CNT_WIDTH +: CNT_WIDTH] = wm;
`else
      assign watermark_o[k*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
   end
   assign vec_nxt = (clear_i || !enable_i) ? '0 : (interruption_vector_rdc_o | over);
   // summary registered from next vector so it rises with the first flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         interruption_vector_rdc_o <= '0;
         interruption_rdc_o        <= 1'b0;
      end else begin
         interruption_vector_rdc_o <= vec_nxt;
         interruption_rdc_o        <= |vec_nxt;
      end
   end
endmodule
